// File: rtl/scalar_issue_ctl_pkg.sv
// scalar_issue_ctl_pkg: opcode classes, result-mux unit encoding and default
// functional-unit latencies shared by the scalar issue and write-back logic.
package scalar_issue_ctl_pkg;

  typedef enum logic [1:0] {
    UNIT_ADD = 2'd0,
    UNIT_LOG = 2'd1,
    UNIT_SHF = 2'd2,
    UNIT_POP = 2'd3
  } unit_t;

  localparam logic [6:0] OP_ADD_LO = 7'o060;
  localparam logic [6:0] OP_ADD_HI = 7'o061;
  localparam logic [6:0] OP_LOG_LO = 7'o044;
  localparam logic [6:0] OP_LOG_HI = 7'o051;
  localparam logic [6:0] OP_SHF_LO = 7'o052;
  localparam logic [6:0] OP_SHF_HI = 7'o057;
  localparam logic [6:0] OP_POP_LO = 7'o026;
  localparam logic [6:0] OP_POP_HI = 7'o027;

  localparam int DEF_ADD_LAT = 3;
  localparam int DEF_LOG_LAT = 1;
  localparam int DEF_SHF_LAT = 2;
  localparam int DEF_POP_LAT = 4;
  localparam int DEF_MAX_LAT = 4;

  typedef struct packed {
    logic       vld;
    logic [2:0] addr;
    unit_t      unit;
  } resv_t;

  typedef struct packed {
    logic  handled;
    unit_t unit;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] op);
    return (op >= OP_ADD_LO && op <= OP_ADD_HI) ? dec_t'{handled: 1'b1, unit: UNIT_ADD} :
           (op >= OP_LOG_LO && op <= OP_LOG_HI) ? dec_t'{handled: 1'b1, unit: UNIT_LOG} :
           (op >= OP_SHF_LO && op <= OP_SHF_HI) ? dec_t'{handled: 1'b1, unit: UNIT_SHF} :
           (op >= OP_POP_LO && op <= OP_POP_HI) ? dec_t'{handled: 1'b1, unit: UNIT_POP} :
                                                  dec_t'{handled: 1'b0, unit: UNIT_ADD};
  endfunction

endpackage

// File: rtl/scalar_issue_ctl_if.sv
// scalar_issue_ctl_if: instruction-issue and write-back signals of the scalar issue controller.
interface scalar_issue_ctl_if;
  logic       i_valid;
  logic [6:0] i_instr;
  logic [2:0] i_i;
  logic [2:0] i_j;
  logic [2:0] i_k;
  logic       i_flush;
  logic       o_ready;
  logic       o_add_go;
  logic       o_log_go;
  logic       o_shf_go;
  logic       o_pop_go;
  logic       o_unhandled;
  logic       o_wb_valid;
  logic [2:0] o_wb_addr;
  logic [1:0] o_wb_unit;
  logic [7:0] o_busy;

  modport master (
    output i_valid, i_instr, i_i, i_j, i_k, i_flush,
    input  o_ready, o_add_go, o_log_go, o_shf_go, o_pop_go, o_unhandled,
    input  o_wb_valid, o_wb_addr, o_wb_unit, o_busy
  );

  modport slave (
    input  i_valid, i_instr, i_i, i_j, i_k, i_flush,
    output o_ready, o_add_go, o_log_go, o_shf_go, o_pop_go, o_unhandled,
    output o_wb_valid, o_wb_addr, o_wb_unit, o_busy
  );
endinterface

// File: rtl/scalar_resv_pipe.sv
// scalar_resv_pipe: result reservation shift register; slot[0] is the write-back
// happening this cycle, slot[n] the one n cycles ahead.
module scalar_resv_pipe
  import scalar_issue_ctl_pkg::*;
#(
  parameter int MAX_LAT = DEF_MAX_LAT,
  parameter int LW      = $clog2(MAX_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          accept,
  input  logic [LW-1:0] lat,
  input  resv_t         entry,
  output logic          conflict,
  output resv_t         head,
  output logic [7:0]    busy
);

  resv_t slot [MAX_LAT+1];

  // slot[lat] is sampled before the shift: it lands in slot[0] exactly lat cycles out
  assign conflict = slot[lat].vld;
  assign head     = slot[0];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int n = 0; n <= MAX_LAT; n++) slot[n] <= '0;
    else if (flush)
      for (int n = 0; n <= MAX_LAT; n++) slot[n] <= '0;
    else begin
      for (int n = 0; n < MAX_LAT; n++)
        slot[n] <= (accept && n == int'(lat) - 1) ? entry : slot[n+1];
      slot[MAX_LAT] <= '0;
    end

  always_comb begin
    busy = '0;
    for (int n = 0; n <= MAX_LAT; n++)
      if (slot[n].vld) busy[slot[n].addr] = 1'b1;
  end

endmodule

// File: rtl/scalar_issue_ctl.sv
// scalar_issue_ctl: issues scalar add/logical/shift/pop instructions after S-register
// hazard and result-path checks, then steers write-back when each result is valid.
module scalar_issue_ctl
  import scalar_issue_ctl_pkg::*;
#(
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int LOG_LAT = DEF_LOG_LAT,
  parameter int SHF_LAT = DEF_SHF_LAT,
  parameter int POP_LAT = DEF_POP_LAT,
  parameter int MAX_LAT = DEF_MAX_LAT
) (
  input logic               clk,
  input logic               rst_n,
  scalar_issue_ctl_if.slave bus
);

  localparam int LW = $clog2(MAX_LAT + 1);

  dec_t          dec;
  logic [LW-1:0] lat;
  logic          conflict;
  logic          hazard;
  logic          accept;
  resv_t         entry;
  resv_t         head;
  logic [7:0]    busy;

  always_comb begin
    dec    = decode(bus.i_instr);
    lat    = dec.unit == UNIT_ADD ? LW'(ADD_LAT) :
             dec.unit == UNIT_LOG ? LW'(LOG_LAT) :
             dec.unit == UNIT_SHF ? LW'(SHF_LAT) : LW'(POP_LAT);
    hazard = busy[bus.i_i] | busy[bus.i_j] | busy[bus.i_k] | conflict | bus.i_flush;
    accept = bus.i_valid && dec.handled && !hazard;
    entry  = '{vld: 1'b1, addr: bus.i_i, unit: dec.unit};
  end

  assign bus.o_ready     = !dec.handled || !hazard;
  assign bus.o_add_go    = accept && dec.unit == UNIT_ADD;
  assign bus.o_log_go    = accept && dec.unit == UNIT_LOG;
  assign bus.o_shf_go    = accept && dec.unit == UNIT_SHF;
  assign bus.o_pop_go    = accept && dec.unit == UNIT_POP;
  assign bus.o_unhandled = bus.i_valid && !dec.handled;
  assign bus.o_wb_valid  = head.vld;
  assign bus.o_wb_addr   = head.addr;
  assign bus.o_wb_unit   = head.unit;
  assign bus.o_busy      = busy;

  scalar_resv_pipe #(.MAX_LAT(MAX_LAT), .LW(LW)) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.i_flush),
    .accept   (accept),
    .lat      (lat),
    .entry    (entry),
    .conflict (conflict),
    .head     (head),
    .busy     (busy)
  );

endmodule

// File: tb/tb_scalar_issue_ctl.sv
// tb_scalar_issue_ctl: directed issue sequences with a write-back scoreboard
// checked every cycle on the falling edge.
module tb_scalar_issue_ctl;

  typedef struct {
    int         cyc;
    logic [2:0] addr;
    logic [1:0] unit;
  } wb_t;

  logic clk = 1'b0;
  logic rst_n;
  logic mon_en = 1'b0;
  int   cyc;
  int   n_cmp = 0;
  int   n_err = 0;
  wb_t  sb[$];
  int   hit;

  scalar_issue_ctl_if bus ();

  scalar_issue_ctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // class of an opcode: 0 add, 1 logical, 2 shift, 3 pop, -1 not a scalar unit op
  function automatic int cls(input logic [6:0] op);
    if (op == 7'o060 || op == 7'o061) return 0;
    if (op >= 7'o044 && op <= 7'o051) return 1;
    if (op >= 7'o052 && op <= 7'o057) return 2;
    if (op == 7'o026 || op == 7'o027) return 3;
    return -1;
  endfunction

  function automatic int lat_of(input int c);
    return c == 0 ? 3 : c == 1 ? 1 : c == 2 ? 2 : 4;
  endfunction

  always @(negedge clk) if (mon_en) begin
    hit = -1;
    foreach (sb[q]) if (sb[q].cyc == cyc) hit = q;
    if (hit >= 0) begin
      chk("wb_valid", 32'(bus.o_wb_valid), 32'd1);
      chk("wb_addr", 32'(bus.o_wb_addr), 32'(sb[hit].addr));
      chk("wb_unit", 32'(bus.o_wb_unit), 32'(sb[hit].unit));
      sb.delete(hit);
    end else
      chk("wb_idle", 32'(bus.o_wb_valid), 32'd0);
  end

  // one cycle: drive, check handshake (and busy unless busy_exp < 0), predict write-back
  task automatic op(input string tag, input logic v, input logic [6:0] opc,
                    input logic [2:0] i, input logic [2:0] j, input logic [2:0] k,
                    input logic fl, input logic rdy, input int busy_exp);
    int c;
    logic [3:0] go;
    c = cls(opc);
    bus.i_valid = v;
    bus.i_instr = opc;
    bus.i_i     = i;
    bus.i_j     = j;
    bus.i_k     = k;
    bus.i_flush = fl;
    @(negedge clk);
    go = (v && rdy && c >= 0) ? 4'b0001 << c : 4'b0000;
    chk({tag, "_ready"}, 32'(bus.o_ready), 32'(rdy));
    chk({tag, "_go"}, 32'({bus.o_pop_go, bus.o_shf_go, bus.o_log_go, bus.o_add_go}), 32'(go));
    chk({tag, "_unh"}, 32'(bus.o_unhandled), 32'(v && rdy && c < 0));
    if (busy_exp >= 0) chk({tag, "_busy"}, 32'(bus.o_busy), 32'(busy_exp));
    if (fl)
      for (int q = sb.size() - 1; q >= 0; q--) if (sb[q].cyc > cyc) sb.delete(q);
    if (go != 4'b0000) sb.push_back('{cyc: cyc + lat_of(c), addr: i, unit: 2'(c)});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int busy_exp);
    op("idle", 1'b0, 7'o000, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, busy_exp);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_instr = 7'o060;
    bus.i_i = 3'd1;
    bus.i_j = 3'd2;
    bus.i_k = 3'd3;
    bus.i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_wb_valid", 32'(bus.o_wb_valid), 32'd0);
    chk("rst_wb_addr", 32'(bus.o_wb_addr), 32'd0);
    chk("rst_wb_unit", 32'(bus.o_wb_unit), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_add_go", 32'(bus.o_add_go), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    // add latency and busy window
    op("add", 1'b1, 7'o060, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 0);
    idle(8'h02); idle(8'h02); idle(8'h02); idle(0);
    // RAW on S1 stalls the logical op until the add has written back
    op("raw_add", 1'b1, 7'o060, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 0);
    op("raw_log", 1'b1, 7'o044, 3'd4, 3'd1, 3'd0, 1'b0, 1'b0, 8'h02);
    op("raw_log", 1'b1, 7'o044, 3'd4, 3'd1, 3'd0, 1'b0, 1'b0, 8'h02);
    op("raw_log", 1'b1, 7'o044, 3'd4, 3'd1, 3'd0, 1'b0, 1'b0, 8'h02);
    op("raw_log", 1'b1, 7'o044, 3'd4, 3'd1, 3'd0, 1'b0, 1'b1, 0);
    idle(8'h10); idle(0);
    // result-path conflict: pop and add would both land on the same cycle
    op("conf_pop", 1'b1, 7'o026, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 0);
    op("conf_add", 1'b1, 7'o060, 3'd6, 3'd0, 3'd0, 1'b0, 1'b0, 8'h20);
    op("conf_add", 1'b1, 7'o061, 3'd6, 3'd0, 3'd0, 1'b0, 1'b1, 8'h20);
    idle(8'h60); idle(8'h60); idle(8'h40); idle(0);
    // back-to-back logical ops
    op("b2b1", 1'b1, 7'o044, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 0);
    op("b2b2", 1'b1, 7'o047, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 8'h02);
    op("b2b3", 1'b1, 7'o051, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 8'h04);
    idle(8'h08); idle(0);
    // flush discards a pending shift result and blocks the flush-cycle issue
    op("fl_shf", 1'b1, 7'o052, 3'd7, 3'd0, 3'd0, 1'b0, 1'b1, 0);
    op("fl_req", 1'b1, 7'o060, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 8'h80);
    idle(0); idle(0);
    // flush leaves the write-back already in slot 0 intact
    op("fl_log", 1'b1, 7'o050, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 0);
    op("fl_cmt", 1'b0, 7'o000, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 8'h08);
    idle(0);
    // unhandled opcode, and unhandled beside a pending write
    op("unh", 1'b1, 7'o005, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 0);
    op("shf_max", 1'b1, 7'o057, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 0);
    op("unh_busy", 1'b1, 7'o077, 3'd4, 3'd4, 3'd4, 1'b0, 1'b1, 8'h10);
    idle(8'h10); idle(0);
    // reset mid-flight loses the pop result
    op("rst_pop", 1'b1, 7'o027, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 0);
    idle(8'h20);
    rst_n = 1'b0;
    sb.delete();
    idle(0); idle(0);
    rst_n = 1'b1;
    idle(0); idle(0); idle(0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scalar_issue_ctl.md
# scalar_issue_ctl

Issue controller for the scalar functional units (scalar add, scalar logical, scalar shift, population/leading-zero count) of the Cray-XMP CPU. It accepts one decoded scalar instruction per cycle and checks S-register hazards and result-path conflicts. It fires the selected unit's go strobe and tracks every in-flight result in a reservation pipeline. It then drives the S-register write-back address and result-mux select in the exact cycle each unit's output is valid.

## Interface
Parameters:
- ADD_LAT, 3, scalar add functional time (instr 060/061)
- LOG_LAT, 1, scalar logical functional time (instr 044–051)
- SHF_LAT, 2, scalar shift functional time (instr 052–057)
- POP_LAT, 4, pop/leading-zero count functional time (instr 026/027)
- MAX_LAT, 4, depth of reservation pipeline; must be ≥ every *_LAT and every *_LAT ≥ 1

Ports:
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  instruction presented this cycle
- i_instr  in  7  opcode (octal gh field)
- i_i  in  3  destination Si
- i_j  in  3  source Sj
- i_k  in  3  source Sk
- i_flush  in  1  discard all pending reservations (exchange/interrupt)
- o_ready  out  1  instruction accepted when i_valid && o_ready
- o_add_go, o_log_go, o_shf_go, o_pop_go  out  1 each  unit select, combinational, same cycle as accept
- o_unhandled  out  1  accepted opcode outside the four classes
- o_wb_valid  out  1  write Si this cycle
- o_wb_addr  out  3  Si address for write-back
- o_wb_unit  out  2  result mux select: 0 add, 1 logical, 2 shift, 3 pop
- o_busy  out  8  per-S-register pending-write mask

## Operation
- Decode: 060/061→add, 044–051→logical, 052–057→shift, 026/027→pop; L = class latency.
- Unhandled opcode with i_valid: o_ready=1, o_unhandled=1, no go, no reservation.
- Handled opcode stalls (o_ready=0) if any of the following holds: o_busy[i_j], o_busy[i_k], o_busy[i_i] (RAW/WAW); an entry is already scheduled to write back in cycle t+L (result-path conflict); i_flush=1.
- Accept in cycle t: exactly one go strobe high in t; a reservation {addr=i_i, unit} is entered to write back in cycle t+L.
- Reservation pipeline: slots 0..MAX_LAT. Each cycle slot[n]←slot[n+1]; accept writes slot[L-1]. Conflict test reads slot[L] before the shift. o_wb_* = slot[0].
- o_busy = OR of one-hot(addr) over all valid slots including slot[0]. A dependent instruction issues no earlier than t+L+1.
- i_flush: all slots invalid next cycle; any o_wb_valid in the flush cycle still asserts (already committed); no accept in the flush cycle.
- Go strobes, o_unhandled are 0 whenever i_valid=0 or o_ready=0.

## Timing
- Reset (async assert, sync release by clk): all slots invalid; o_wb_valid=0, o_wb_addr=0, o_wb_unit=0, o_busy=0. Combinational go strobes and o_ready follow inputs (o_ready=1 for a handled op with no hazard).
- Reset mid-operation: in-flight results are lost; unit outputs arriving later are never written.
- Add issued cycle t: o_add_go in t, o_wb_valid/o_wb_addr=i_i/o_wb_unit=0 in t+3, o_busy[i] high t+1..t+3.
- Max throughput: one accept per cycle when destinations are distinct and latencies do not collide.

## Structure
- Shared package holds the opcode class constants, unit-select encoding (0..3) and default latencies. These are shared with the instruction-issue block and the S-register write mux.
- One natural sub-module: scalar_resv_pipe (the slot shift register with conflict lookup and busy-mask generation).

## Test plan
- Reset then 060 i=1 j=2 k=3 at cycle 0: o_add_go cycle 0; o_wb_valid, addr 1, unit 0 at cycle 3 only; o_busy=8'h02 cycles 1–3.
- 060 i=1 at cycle 0, then 044 i=4 j=1 at cycle 1: stalled through cycle 3, accepted cycle 4, wb addr 4 unit 1 at cycle 5.
- 026 i=5 (L=4) at cycle 0, 060 i=6 (L=3) at cycle 1: add stalls (both target cycle 4), accepted cycle 2, wb addr 5 at 4 and addr 6 at 5.
- Back-to-back 044 i=1, i=2, i=3 cycles 0–2: all accepted, wb addrs 1,2,3 at cycles 1,2,3.
- 052 i=7 at cycle 0, i_flush cycle 1: o_wb_valid stays 0 at cycle 2, o_busy=0 from cycle 2; i_valid with flush in cycle 1 gives o_ready=0.
- Opcode 005 with i_valid: o_ready=1, o_unhandled=1, no go, o_busy unchanged; rst_n low at cycle 2 after a 026 issue: no write-back ever.
